// File: rtl/arb_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared types and helpers for the request arbiter.
//   state_t  : arbiter FSM encoding (IDLE = no owner, GRANT = owner valid)
//   ARB_N    : default requester count
//   ID_W     : default requester index width
//   onehot() : index -> one-hot vector, sized for the largest supported N
// -----------------------------------------------------------------------------
package arb_pkg;

  localparam int ARB_N    = 4;
  localparam int ID_W     = $clog2(ARB_N);
  localparam int MAX_N    = 8;
  localparam int MAX_ID_W = 3;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // Callers truncate the result to their own requester count.
  function automatic logic [MAX_N-1:0] onehot(input logic [MAX_ID_W-1:0] id);
    logic [MAX_N-1:0] v;
    v     = {MAX_N{1'b0}};
    v[id] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/arb_pick.sv
// -----------------------------------------------------------------------------
// arb_pick
// Combinational winner selection over a candidate mask.
// Ports:
//   i_mask   in  N   candidate requesters
//   i_start  in  W   first index examined in round-robin mode
//   i_rr_en  in  1   1 = round-robin search from i_start, 0 = highest index wins
//   o_winner out W   selected index (0 when nothing is set)
//   o_any    out 1   at least one candidate was set
// -----------------------------------------------------------------------------
module arb_pick
  import arb_pkg::*;
#(
  parameter int N = ARB_N,
  parameter int W = ID_W
) (
  input  logic [N-1:0] i_mask,
  input  logic [W-1:0] i_start,
  input  logic         i_rr_en,
  output logic [W-1:0] o_winner,
  output logic         o_any
);

  localparam int W1 = W + 1;

  logic [W1-1:0] w_idx;
  logic          w_found;

  // Winner search: rotating scan in RR mode, last-set-wins scan in fixed mode.
  always_comb begin
    w_idx    = {W1{1'b0}};
    w_found  = 1'b0;
    o_winner = {W{1'b0}};
    if (i_rr_en) begin
      for (int k = 0; k < N; k++) begin
        // One extra bit so start+k never overflows before the wrap.
        w_idx = {1'b0, i_start} + W1'(k);
        if (w_idx >= W1'(N)) begin
          w_idx = w_idx - W1'(N);
        end else begin
          w_idx = w_idx;
        end
        if (!w_found && i_mask[w_idx[W-1:0]]) begin
          o_winner = w_idx[W-1:0];
          w_found  = 1'b1;
        end else begin
          w_found  = w_found;
        end
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        if (i_mask[k]) begin
          o_winner = W'(k);
          w_found  = 1'b1;
        end else begin
          w_found  = w_found;
        end
      end
    end
    o_any = w_found;
  end

endmodule

// File: rtl/req_arbiter.sv
// -----------------------------------------------------------------------------
// req_arbiter
// Grants one of N requesters access to a shared resource. The grant is held
// while the owner keeps requesting, up to MAX_HOLD consecutive cycles, after
// which any other pending requester preempts it.
// Ports:
//   clk        in  1         rising-edge clock
//   rst_n      in  1         asynchronous active-low reset
//   req        in  N         level requests
//   rr_en      in  1         1 = round-robin, 0 = fixed priority (highest index)
//   gnt        out N         registered one-hot grant
//   gnt_id     out clog2(N)  index of current / last owner
//   gnt_valid  out 1         |gnt
//   preempt    out 1         one-cycle pulse when a grant is taken by timeout
// -----------------------------------------------------------------------------
module req_arbiter
  import arb_pkg::*;
#(
  parameter int N        = ARB_N,
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic                 rr_en,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 gnt_valid,
  output logic                 preempt
);

  localparam int GW = $clog2(N);
  localparam int HW = $clog2(MAX_HOLD);

  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [GW-1:0] ID_LAST   = GW'(N - 1);

  state_t        r_state;
  logic [HW-1:0] r_hold_cnt;
  logic [GW-1:0] r_last;

  logic          w_own_req;
  logic          w_timeout;
  logic [N-1:0]  w_own_oh;
  logic [N-1:0]  w_mask;
  logic [GW-1:0] w_start;
  logic [GW-1:0] w_winner;
  logic          w_any;
  logic [N-1:0]  w_win_oh;

  state_t        w_state_nxt;
  logic [HW-1:0] w_hold_nxt;
  logic [GW-1:0] w_last_nxt;
  logic [N-1:0]  w_gnt_nxt;
  logic [GW-1:0] w_id_nxt;
  logic          w_pre_nxt;
  logic          w_take;

  assign w_own_req = req[gnt_id];
  assign w_timeout = (r_state == ST_GRANT) && w_own_req && (r_hold_cnt == HOLD_LAST);
  assign w_own_oh  = N'(onehot(MAX_ID_W'(gnt_id)));
  // On timeout the owner is removed from the candidates so someone else can win.
  assign w_mask    = w_timeout ? (req & ~w_own_oh) : req;
  // Reset value of r_last is N-1, so the first RR search starts at index 0.
  assign w_start   = (r_last == ID_LAST) ? {GW{1'b0}} : (r_last + GW'(1));
  assign w_win_oh  = N'(onehot(MAX_ID_W'(w_winner)));

  arb_pick #(
    .N (N),
    .W (GW)
  ) u_pick (
    .i_mask   (w_mask),
    .i_start  (w_start),
    .i_rr_en  (rr_en),
    .o_winner (w_winner),
    .o_any    (w_any)
  );

  // FSM next-state: hold, release/re-arbitrate, or timeout/preempt.
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold_cnt;
    w_last_nxt  = r_last;
    w_gnt_nxt   = gnt;
    w_id_nxt    = gnt_id;
    w_pre_nxt   = 1'b0;
    w_take      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_take    = 1'b1;
        end else begin
          w_gnt_nxt = {N{1'b0}};
        end
      end
      ST_GRANT: begin
        if (!w_own_req) begin
          // Release: hand over on the same edge when anyone else is waiting.
          if (w_any) begin
            w_take      = 1'b1;
          end else begin
            w_gnt_nxt   = {N{1'b0}};
            w_state_nxt = ST_IDLE;
            w_hold_nxt  = {HW{1'b0}};
          end
        end else if (r_hold_cnt != HOLD_LAST) begin
          w_hold_nxt = r_hold_cnt + HW'(1);
        end else begin
          // Timeout: preempt if possible, otherwise the sole owner restarts its window.
          if (w_any) begin
            w_take     = 1'b1;
            w_pre_nxt  = 1'b1;
          end else begin
            w_hold_nxt = {HW{1'b0}};
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = {N{1'b0}};
        w_hold_nxt  = {HW{1'b0}};
      end
    endcase
    if (w_take) begin
      w_state_nxt = ST_GRANT;
      w_gnt_nxt   = w_win_oh;
      w_id_nxt    = w_winner;
      w_last_nxt  = w_winner;
      w_hold_nxt  = {HW{1'b0}};
    end else begin
      w_state_nxt = w_state_nxt;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_hold_cnt <= {HW{1'b0}};
      r_last     <= ID_LAST;
      gnt        <= {N{1'b0}};
      gnt_id     <= {GW{1'b0}};
      gnt_valid  <= 1'b0;
      preempt    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_last     <= w_last_nxt;
      gnt        <= w_gnt_nxt;
      gnt_id     <= w_id_nxt;
      gnt_valid  <= |w_gnt_nxt;
      preempt    <= w_pre_nxt;
    end
  end

endmodule
